// File: rtl/fetch_unit.sv
// Instruction-fetch / PC sequencer: fetches from a 1-cycle block-RAM, hands the
// word to the decoder, and computes the next PC once execute commits.
module fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       imem_dout,
    output logic              imem_ren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       instr,
    output logic              dec_en,
    input  logic              decoder_done,
    input  logic              exec_done,
    input  logic              take_branch,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic [25:0]       jump_address,
    input  logic [31:0]       branch_offset,
    input  logic [31:0]       reg_target,
    input  logic              exit_instruction,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       instr_count,
    output logic              halted,
    output logic              misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEM,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state, state_next;
    logic        first_decode;
    logic [31:0] pc_next;
    logic        misaligned_next;
    logic        retire;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[ADDR_W+1:2];
    assign retire    = (state == S_EXEC) && exec_done;

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        misaligned_next = misaligned;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  state_next = S_MEM;
            S_MEM:    state_next = S_DECODE;
            // decoder_done may still be high from the previous instruction
            S_DECODE: if (!first_decode && decoder_done) state_next = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    if (exit_instruction) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_FETCH;
                        if (jump_reg) begin
                            pc_next = {reg_target[31:2], 2'b00};
                            if (reg_target[1:0] != 2'b00) misaligned_next = 1'b1;
                        end else if (jump) begin
                            pc_next = {pc_plus4[31:28], jump_address, 2'b00};
                        end else if (take_branch) begin
                            pc_next = pc_plus4 + {branch_offset[29:0], 2'b00};
                        end else begin
                            pc_next = pc_plus4;
                        end
                    end
                end
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            instr        <= 32'd0;
            dec_en       <= 1'b0;
            imem_ren     <= 1'b0;
            instr_count  <= 32'd0;
            halted       <= 1'b0;
            misaligned   <= 1'b0;
            first_decode <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            misaligned   <= misaligned_next;
            imem_ren     <= (state_next == S_FETCH);
            dec_en       <= (state_next == S_DECODE);
            halted       <= (state_next == S_HALT);
            first_decode <= (state_next == S_DECODE) && (state != S_DECODE);
            if (state == S_MEM) instr <= imem_dout;
            if (retire) instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives control flags per instruction and
// compares PC, counters and strobes against hand-computed values.
module tb_fetch_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       imem_dout;
    logic              imem_ren;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       instr;
    logic              dec_en;
    logic              decoder_done = 1'b1;
    logic              exec_done = 1'b0;
    logic              take_branch = 1'b0;
    logic              jump = 1'b0;
    logic              jump_reg = 1'b0;
    logic [25:0]       jump_address = 26'd0;
    logic [31:0]       branch_offset = 32'd0;
    logic [31:0]       reg_target = 32'd0;
    logic              exit_instruction = 1'b0;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic [31:0]       instr_count;
    logic              halted;
    logic              misaligned;

    logic [31:0] imem [0:(1<<ADDR_W)-1];
    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_dout(imem_dout),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .instr(instr), .dec_en(dec_en),
        .decoder_done(decoder_done), .exec_done(exec_done), .take_branch(take_branch),
        .jump(jump), .jump_reg(jump_reg), .jump_address(jump_address),
        .branch_offset(branch_offset), .reg_target(reg_target),
        .exit_instruction(exit_instruction), .pc(pc), .pc_plus4(pc_plus4),
        .instr_count(instr_count), .halted(halted), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_ren) imem_dout <= imem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait until the DUT has left DECODE (dec_en seen high, then low) = EXEC.
    task automatic wait_exec(input string tag);
        bit seen = 0;
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dec_en) seen = 1;
            else if (seen) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_reach_exec"}, {31'd0, ok}, 32'd1);
    endtask

    // One instruction: flags = {exit, jump_reg, jump, take_branch}
    task automatic run_instr(input string tag, input logic [3:0] flags,
                             input logic [25:0] ja, input logic [31:0] bo,
                             input logic [31:0] rt, input logic [31:0] exp_pc,
                             input logic [31:0] exp_cnt);
        wait_exec(tag);
        {exit_instruction, jump_reg, jump, take_branch} = flags;
        jump_address  = ja;
        branch_offset = bo;
        reg_target    = rt;
        exec_done     = 1'b1;
        @(negedge clk);
        {exit_instruction, jump_reg, jump, take_branch} = 4'b0000;
        exec_done = 1'b0;
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_cnt"}, instr_count, exp_cnt);
        $display("instr %s: pc=%h count=%0d misaligned=%0b halted=%0b",
                 tag, pc, instr_count, misaligned, halted);
    endtask

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) imem[i] = 32'h1000_0000 + i;
        imem[0] = 32'h2008_0005;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_ren", {31'd0, imem_ren}, 32'd0);
        check("rst_instr", instr, 32'h0);

        // reset mid-DECODE aborts immediately with no retire
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_dec_en", {31'd0, dec_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_dec_en", {31'd0, dec_en}, 32'd0);
        check("abort_instr", instr, 32'h0);
        check("abort_cnt", instr_count, 32'd0);
        check("abort_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // start timing: FETCH, MEM, DECODE x2, EXEC
        @(negedge clk);
        check("idle_hold_ren", {31'd0, imem_ren}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("c1_ren", {31'd0, imem_ren}, 32'd1);
        check("c1_addr", {22'd0, imem_addr}, 32'd0);
        @(negedge clk);
        check("c2_ren", {31'd0, imem_ren}, 32'd0);
        @(negedge clk);
        check("c3_instr", instr, 32'h2008_0005);
        check("c3_dec_en", {31'd0, dec_en}, 32'd1);
        @(negedge clk);
        check("c4_dec_en", {31'd0, dec_en}, 32'd1);
        @(negedge clk);
        check("c5_dec_en", {31'd0, dec_en}, 32'd0);

        // In EXEC already: retire with jump to word 4 -> 0x10.
        {exit_instruction, jump_reg, jump, take_branch} = 4'b0010;
        jump_address = 26'h4;
        exec_done = 1'b1;
        @(negedge clk);
        {exit_instruction, jump_reg, jump, take_branch} = 4'b0000;
        exec_done = 1'b0;
        check("j10_pc", pc, 32'h10);
        check("j10_cnt", instr_count, 32'd1);

        run_instr("seq", 4'b0000, 26'd0, 32'd0, 32'd0, 32'h14, 32'd2);
        check("seq_addr", {22'd0, imem_addr}, 32'd5);
        check("seq_instr_next", pc_plus4, 32'h18);
        run_instr("j20a", 4'b0010, 26'h8, 32'd0, 32'd0, 32'h20, 32'd3);
        run_instr("beq_neg", 4'b0001, 26'd0, 32'hFFFF_FFFE, 32'd0, 32'h1C, 32'd4);
        run_instr("j20b", 4'b0010, 26'h8, 32'd0, 32'd0, 32'h20, 32'd5);
        run_instr("beq_pos", 4'b0001, 26'd0, 32'd3, 32'd0, 32'h30, 32'd6);
        run_instr("jr_hi", 4'b0100, 26'd0, 32'd0, 32'h4000_0040, 32'h4000_0040, 32'd7);
        check("jr_hi_mis", {31'd0, misaligned}, 32'd0);
        check("jr_hi_addr", {22'd0, imem_addr}, 32'h010);
        run_instr("j_pri", 4'b0011, 26'h10, 32'd5, 32'd0, 32'h4000_0040, 32'd8);
        run_instr("jr_mis", 4'b0110, 26'h3, 32'd0, 32'h0000_0083, 32'h80, 32'd9);
        check("jr_mis_flag", {31'd0, misaligned}, 32'd1);
        run_instr("seq2", 4'b0000, 26'd0, 32'd0, 32'd0, 32'h84, 32'd10);
        check("mis_sticky", {31'd0, misaligned}, 32'd1);
        run_instr("exit", 4'b1010, 26'h8, 32'd0, 32'd0, 32'h84, 32'd11);
        check("exit_halted", {31'd0, halted}, 32'd1);

        // HALT ignores start and exec_done
        start = 1'b1;
        exec_done = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        exec_done = 1'b0;
        @(negedge clk);
        check("halt_pc", pc, 32'h84);
        check("halt_cnt", instr_count, 32'd11);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_ren", {31'd0, imem_ren}, 32'd0);
        check("halt_dec_en", {31'd0, dec_en}, 32'd0);

        // reset leaves HALT
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_halted", {31'd0, halted}, 32'd0);
        check("post_rst_mis", {31'd0, misaligned}, 32'd0);
        check("post_rst_pc", pc, 32'h0);
        check("post_rst_cnt", instr_count, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_ren", {31'd0, imem_ren}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
